instr_fetch_unit: RTL and testbench

- Front-end sequencer that produces the instruction stream consumed by the instruction decoder.
- Drives the PC and a 1-cycle-latency synchronous instruction memory.
- Buffers fetched words in a small FIFO and presents them with a valid/ready handshake.
- Redirects fetch and flushes stale words when the decoder asserts a taken branch (pc_src).

---
 rtl/instr_fetch_unit_if.sv | 25 ++
 rtl/instr_fetch_unit.sv | 87 ++++++++
 tb/tb_instr_fetch_unit.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: bundles the instruction-memory read port and the decoder-side
// valid/ready stream with its branch-redirect inputs.
interface instr_fetch_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  imem_req;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [DATA_WIDTH-1:0] imem_rdata;
    logic [DATA_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] instr_pc;
    logic                  instr_valid;
    logic                  instr_ready;
    logic                  pc_src;
    logic [ADDR_WIDTH-1:0] br_pc;
    logic [ADDR_WIDTH-1:0] imm_op;
    modport master (
        output imem_req, imem_addr, instr, instr_pc, instr_valid,
        input  imem_rdata, instr_ready, pc_src, br_pc, imm_op
    );
    modport slave (
        input  imem_req, imem_addr, instr, instr_pc, instr_valid,
        output imem_rdata, instr_ready, pc_src, br_pc, imm_op
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC sequencer for a 1-cycle synchronous instruction memory, buffering
// returned words in a small FIFO drained by the decoder and flushed on taken branches.
module instr_fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    FIFO_DEPTH = 3
) (
    input logic                clk,
    input logic                rst_n,
    instr_fetch_unit_if.master bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int KW = CW + 1;
    localparam logic [PW-1:0] LAST = PW'(FIFO_DEPTH - 1);

    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d, tag_q, tag_d;
    logic                  inflight_q, inflight_d;
    logic [CW-1:0]         count_q, count_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [DATA_WIDTH-1:0] data_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] data_d [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] pcs_q [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] pcs_d [FIFO_DEPTH];
    logic                  issue, push, pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return p == LAST ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        // credit counts the in-flight word so a returning read always has a free slot
        issue      = rst_n && !bus.pc_src && ({1'b0, count_q} + KW'(inflight_q)) < KW'(FIFO_DEPTH);
        push       = inflight_q && !bus.pc_src;
        pop        = count_q != '0 && bus.instr_ready;
        fetch_pc_d = issue ? fetch_pc_q + ADDR_WIDTH'(4) : fetch_pc_q;
        tag_d      = issue ? fetch_pc_q : tag_q;
        inflight_d = issue;
        data_d     = data_q;
        pcs_d      = pcs_q;
        count_d    = count_q + CW'(push) - CW'(pop);
        rd_ptr_d   = pop ? bump(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d   = push ? bump(wr_ptr_q) : wr_ptr_q;
        if (push) begin
            data_d[wr_ptr_q] = bus.imem_rdata;
            pcs_d[wr_ptr_q]  = tag_q;
        end
        if (bus.pc_src) begin
            fetch_pc_d = bus.br_pc + bus.imm_op;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            tag_q      <= '0;
            inflight_q <= 1'b0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            data_q     <= '{default: '0};
            pcs_q      <= '{default: '0};
        end else begin
            fetch_pc_q <= fetch_pc_d;
            tag_q      <= tag_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            data_q     <= data_d;
            pcs_q      <= pcs_d;
        end
    end

    assign bus.imem_req    = issue;
    assign bus.imem_addr   = fetch_pc_q;
    assign bus.instr_valid = count_q != '0;
    assign bus.instr       = data_q[rd_ptr_q];
    assign bus.instr_pc    = pcs_q[rd_ptr_q];

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && count_q == CW'(FIFO_DEPTH)));
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: random and directed stimulus against a queue-based model of the
// fetch stream; a second instance checks PC wrap from a high RESET_PC.
module tb_instr_fetch_unit;
    localparam int          D = 3;
    localparam logic [31:0] K = 32'hA5A5_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
    instr_fetch_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus2 ();

    instr_fetch_unit #(.FIFO_DEPTH(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic [31:0] m_pc, m_tag;
    bit          m_inf;
    logic [31:0] q_pc[$];
    bit          req_prev, req2_prev;
    logic [31:0] addr_prev, addr2_prev;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0;
        m_tag = 32'h0;
        m_inf = 1'b0;
        q_pc.delete();
        req_prev = 1'b0;
        req2_prev = 1'b0;
    endtask

    // Called at a negedge: drive inputs, check outputs, advance model at the posedge.
    task automatic step(input bit rdy, input bit src, input logic [31:0] br, input logic [31:0] imm);
        bit exp_req, pop, push;
        bus.instr_ready = rdy;
        bus.pc_src = src;
        bus.br_pc = br;
        bus.imm_op = imm;
        bus.imem_rdata = req_prev ? (addr_prev ^ K) : $urandom;
        bus2.imem_rdata = req2_prev ? (addr2_prev ^ K) : $urandom;
        #1;
        exp_req = !src && (q_pc.size() + int'(m_inf)) < D;
        check("imem_req", {31'b0, bus.imem_req}, {31'b0, exp_req});
        if (exp_req) check("imem_addr", bus.imem_addr, m_pc);
        check("instr_valid", {31'b0, bus.instr_valid}, {31'b0, q_pc.size() != 0});
        if (q_pc.size() != 0) begin
            check("instr_pc", bus.instr_pc, q_pc[0]);
            check("instr", bus.instr, q_pc[0] ^ K);
        end
        req_prev = bus.imem_req;
        addr_prev = bus.imem_addr;
        req2_prev = bus2.imem_req;
        addr2_prev = bus2.imem_addr;
        @(posedge clk);
        pop = q_pc.size() != 0 && rdy;
        push = m_inf && !src;
        if (src) begin
            q_pc.delete();
            m_pc = br + imm;
        end else begin
            if (pop) void'(q_pc.pop_front());
            if (push) q_pc.push_back(m_tag);
        end
        if (exp_req) begin
            m_tag = m_pc;
            m_pc = m_pc + 32'd4;
        end
        m_inf = exp_req;
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        bus.instr_ready = 1'b0;
        bus.pc_src = 1'b0;
        bus.br_pc = '0;
        bus.imm_op = '0;
        bus.imem_rdata = '0;
        bus2.instr_ready = 1'b1;
        bus2.pc_src = 1'b0;
        bus2.br_pc = '0;
        bus2.imm_op = '0;
        bus2.imem_rdata = '0;
        model_reset();
        #12;
        check("rst imem_req", {31'b0, bus.imem_req}, 32'd0);
        check("rst instr_valid", {31'b0, bus.instr_valid}, 32'd0);
        check("rst instr", bus.instr, 32'd0);
        check("rst instr_pc", bus.instr_pc, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        check("wrap addr0", bus2.imem_addr, 32'hFFFF_FFF8);
        step(1, 0, 0, 0);
        check("wrap addr1", bus2.imem_addr, 32'hFFFF_FFFC);
        step(1, 0, 0, 0);
        check("wrap addr2", bus2.imem_addr, 32'h0000_0000);
        check("first valid", {31'b0, bus.instr_valid}, 32'd1);
        check("first pc", bus.instr_pc, 32'h0);
        check("wrap pc0", bus2.instr_pc, 32'hFFFF_FFF8);
        step(1, 0, 0, 0);
        check("wrap pc1", bus2.instr_pc, 32'hFFFF_FFFC);
        step(1, 0, 0, 0);
        check("wrap pc2", bus2.instr_pc, 32'h0000_0000);
        check("wrap data2", bus2.instr, 32'h0 ^ K);

        for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
        check("stall full req", {31'b0, bus.imem_req}, 32'd0);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0);

        step(1, 1, 32'h10, 32'hFFFF_FFF8);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("redir valid", {31'b0, bus.instr_valid}, 32'd1);
        check("redir pc", bus.instr_pc, 32'h8);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);

        step(1, 1, 32'h100, 32'h0);
        step(1, 1, 32'h200, 32'h0);
        check("b2b addr", bus.imem_addr, 32'h200);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("b2b pc", bus.instr_pc, 32'h200);

        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, $urandom,
                 32'($urandom_range(0, 256)) - 32'd128);

        for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        bus.instr_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async imem_req", {31'b0, bus.imem_req}, 32'd0);
        check("async valid", {31'b0, bus.instr_valid}, 32'd0);
        check("async instr", bus.instr, 32'd0);
        check("async instr_pc", bus.instr_pc, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("restart valid", {31'b0, bus.instr_valid}, 32'd1);
        check("restart pc", bus.instr_pc, 32'h0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
